// File: rtl/rvvi_trace_arbiter.sv
// Two-requester round-robin arbiter feeding a single registered trace-record slot.
// Each accepted record is stamped with a global 64-bit retirement order number.
// Optional stall watchdog: define RVVI_ARB_WATCHDOG_EN to build it in; otherwise
// stall_err_o is tied low.
module rvvi_trace_arbiter #(
  parameter int unsigned REC_W      = 128,
  parameter int unsigned TIMEOUT    = 1024,
  // Reset value of the order counter; leave at 0 for normal use
  parameter logic [63:0] ORDER_INIT = '0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [1:0]             req_valid_i,
  input  logic [1:0][REC_W-1:0]  req_rec_i,
  output logic [1:0]             req_ready_o,
  output logic                   out_valid_o,
  output logic [REC_W-1:0]       out_rec_o,
  output logic                   out_src_o,
  output logic [63:0]            out_order_o,
  input  logic                   out_ready_i,
  output logic                   stall_err_o
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [REC_W-1:0]   rec_q, rec_d;
  logic               src_q, src_d;
  logic [63:0]        order_q, order_d;
  logic [63:0]        cnt_q, cnt_d;

  logic [1:0]         grant;
  logic               accept;
  logic               consume;
  logic               acc_idx;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  // Round-robin grant and ready; ready is forced low during reset
  always_comb begin
    grant = 2'b00;
    unique case (req_valid_i)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    if (reset_i) begin
      req_ready_o = 2'b00;
    end else begin
      req_ready_o = grant & {2{(state_q == StEmpty) || out_ready_i}};
    end
    accept  = |req_ready_o;
    consume = (state_q == StFull) && out_ready_i;
    acc_idx = req_ready_o[1];
  end

  // Next-state for the occupancy FSM, output slot, order counter and pointer
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rec_d   = rec_q;
    src_d   = src_q;
    order_d = order_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (consume && !accept) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
    if (accept) begin
      rec_d   = req_rec_i[acc_idx];
      src_d   = acc_idx;
      order_d = cnt_q + 64'd1;
      cnt_d   = cnt_q + 64'd1;
      ptr_d   = ~acc_idx;
    end
  end

  // State registers with synchronous reset; a held record is simply dropped
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StEmpty;
      ptr_q   <= 1'b0;
      rec_q   <= '0;
      src_q   <= 1'b0;
      order_q <= '0;
      cnt_q   <= ORDER_INIT;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rec_q   <= rec_d;
      src_q   <= src_d;
      order_q <= order_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid_o = (state_q == StFull);
  assign out_rec_o   = rec_q;
  assign out_src_o   = src_q;
  assign out_order_o = order_q;

`ifdef RVVI_ARB_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT);

  logic [WdW-1:0] wd_q, wd_d;
  logic           stall_q, stall_d;

  // Count stalled presentation cycles, saturating; flag is sticky until reset
  always_comb begin
    wd_d = wd_q;
    if (consume) begin
      wd_d = '0;
    end else if (out_valid_o && !out_ready_i && (wd_q != WdLimit)) begin
      wd_d = wd_q + WdW'(1);
    end
    stall_d = stall_q || (wd_d == WdLimit);
  end

  // Watchdog registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wd_q    <= '0;
      stall_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      stall_q <= stall_d;
    end
  end

  assign stall_err_o = stall_q;
`else
  assign stall_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rvvi_trace_arbiter.sv
// Self-checking bench for rvvi_trace_arbiter: a slot/queue-level model checked every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_rvvi_trace_arbiter;

  localparam int unsigned REC_W = 128;
  localparam int unsigned TO    = 8;
`ifdef RVVI_ARB_WATCHDOG_EN
  localparam bit WdOn = 1'b1;
`else
  localparam bit WdOn = 1'b0;
`endif

  logic                  clk;
  logic                  reset;
  logic [1:0]            req_valid;
  logic [1:0][REC_W-1:0] req_rec;
  logic                  out_ready;
  logic [1:0]            req_ready;
  logic                  out_valid;
  logic [REC_W-1:0]      out_rec;
  logic                  out_src;
  logic [63:0]           out_order;
  logic                  stall_err;

  logic [1:0]            w_req_ready;
  logic                  w_out_valid;
  logic [REC_W-1:0]      w_out_rec;
  logic                  w_out_src;
  logic [63:0]           w_out_order;
  logic                  w_stall_err;

  int n_cmp = 0;
  int n_bad = 0;

  rvvi_trace_arbiter #(.REC_W(REC_W), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_rec_i(req_rec),
    .req_ready_o(req_ready), .out_valid_o(out_valid), .out_rec_o(out_rec),
    .out_src_o(out_src), .out_order_o(out_order), .out_ready_i(out_ready),
    .stall_err_o(stall_err)
  );

  // Counter starts near the top so the wrap is reached in two records
  rvvi_trace_arbiter #(.REC_W(REC_W), .TIMEOUT(TO), .ORDER_INIT(64'hFFFF_FFFF_FFFF_FFFE)) dut_w (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_rec_i(req_rec),
    .req_ready_o(w_req_ready), .out_valid_o(w_out_valid), .out_rec_o(w_out_rec),
    .out_src_o(w_out_src), .out_order_o(w_out_order), .out_ready_i(out_ready),
    .stall_err_o(w_stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit               chk_en = 1'b0;
  bit               m_full;
  bit               m_ptr;
  logic [REC_W-1:0] m_rec;
  bit               m_src;
  logic [63:0]      m_order;
  logic [63:0]      m_cnt;
  int               m_stalls;
  bit               m_stall;

  always @(negedge clk) begin
    logic [1:0] g;
    logic [1:0] er;
    int         idx;
    g = 2'b00;
    if (req_valid == 2'b01) g = 2'b01;
    else if (req_valid == 2'b10) g = 2'b10;
    else if (req_valid == 2'b11) g = m_ptr ? 2'b10 : 2'b01;
    er = (reset || (m_full && !out_ready)) ? 2'b00 : g;

    if (chk_en) begin
      check("req_ready", req_ready, er);
      check("out_valid", out_valid, m_full);
      check("out_rec", out_rec, m_rec);
      check("out_src", out_src, m_src);
      check("out_order", out_order, m_order);
      check("stall_err", stall_err, m_stall);
    end

    if (reset) begin
      m_full = 0; m_ptr = 0; m_rec = '0; m_src = 0; m_order = '0; m_cnt = '0;
      m_stalls = 0; m_stall = 0;
      chk_en = 1'b1;
    end else begin
      if (m_full && !out_ready) m_stalls++;
      else if (m_full && out_ready) m_stalls = 0;
      if (WdOn && m_stalls >= TO) m_stall = 1;
      if (er != 2'b00) begin
        idx     = er[1] ? 1 : 0;
        m_rec   = req_rec[idx];
        m_src   = er[1];
        m_cnt   = m_cnt + 64'd1;
        m_order = m_cnt;
        m_full  = 1;
        m_ptr   = ~er[1];
      end else if (m_full && out_ready) begin
        m_full = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [1:0] v, input logic [127:0] r0, input logic [127:0] r1,
                       input logic ordy, input logic rst);
    req_valid  = v;
    req_rec[0] = r0;
    req_rec[1] = r1;
    out_ready  = ordy;
    reset      = rst;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(2'b00, '0, '0, 1'b1, 1'b1);
    tick();
    tick();
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_order", out_order, 0);
    check("rst_stall_err", stall_err, 0);

    // Single source
    drive(2'b01, 128'hA5, '0, 1'b1, 1'b0);
    check("single_ready", req_ready, 2'b01);
    tick();
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    check("single_valid", out_valid, 1);
    check("single_rec", out_rec, 128'hA5);
    check("single_src", out_src, 0);
    check("single_order", out_order, 1);
    check("wrap_order_max", w_out_order, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check("single_drain", out_valid, 0);
    drive(2'b01, 128'h5A, '0, 1'b1, 1'b0);
    tick();
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    check("second_order", out_order, 2);
    check("wrap_order_zero", w_out_order, 64'h0);
    check("wrap_valid", w_out_valid, 1);
    tick();

    // Fresh reset so contention starts from ptr = 0
    drive(2'b00, '0, '0, 1'b1, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 128'h100 + k, 128'h200 + k, 1'b1, 1'b0);
      check("cont_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) begin
        check("cont_src", out_src, (k - 1) % 2);
        check("cont_order", out_order, k);
      end
      tick();
    end
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    check("cont_src_last", out_src, 1);
    check("cont_order_last", out_order, 4);
    check("cont_rec_last", out_rec, 128'h203);
    tick();

    // Backpressure
    drive(2'b01, 128'h77, '0, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(2'b10, '0, 128'h88, 1'b0, 1'b0);
      check("bp_ready", req_ready, 2'b00);
      check("bp_rec", out_rec, 128'h77);
      check("bp_order", out_order, 5);
      tick();
    end
    drive(2'b10, '0, 128'h88, 1'b1, 1'b0);
    check("bp_release_ready", req_ready, 2'b10);
    tick();
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    check("bp_next_rec", out_rec, 128'h88);
    check("bp_next_src", out_src, 1);
    check("bp_next_order", out_order, 6);
    tick();

    // Reset while FULL
    drive(2'b01, 128'hC7, '0, 1'b0, 1'b0);
    tick();
    check("mid_full_order", out_order, 7);
    drive(2'b11, 128'h31, 128'h32, 1'b0, 1'b1);
    check("rst_ready_low", req_ready, 2'b00);
    tick();
    drive(2'b11, 128'h31, 128'h32, 1'b1, 1'b0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", req_ready, 2'b01);
    tick();
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    check("mid_rst_order", out_order, 1);
    check("mid_rst_src", out_src, 0);
    tick();

    // Watchdog
    drive(2'b01, 128'h99, '0, 1'b1, 1'b0);
    tick();
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) check("wd_before", stall_err, 0);
    end
    check("wd_set", stall_err, WdOn);
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    tick();
    check("wd_sticky", stall_err, WdOn);
    check("wd_drained", out_valid, 0);
    drive(2'b00, '0, '0, 1'b1, 1'b1);
    tick();
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    check("wd_reset", stall_err, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
